// File: rtl/uart_sched_pkg.sv
// rtl/uart_sched_pkg.sv - shared state encoding and helpers for the UART TX scheduler
package uart_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } sched_state_e;

  // Header low bits carry the channel index, so the base must keep them clear.
  localparam logic [7:0] HDR_MASK = 8'hF8;

  function automatic int seq_bytes(input int frame_bytes, input bit header_en);
    return frame_bytes + (header_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rtl/uart_tx_scheduler_rr_arbiter.sv - combinational round-robin pick
// Searches upward from last_grant+1, wrapping, and returns the first requester.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  last_grant_i,
  output logic              valid_o,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  idx_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    valid_o  = 1'b0;
    grant_o  = '0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = int'(last_grant_i) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      cand_idx = IDX_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o           = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin sharing of one uart_byte_tx among NUM_CH framed requesters
// Latches the winning frame, then sends optional header + payload LSB first with a per-byte watchdog.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int         NUM_CH      = 4,
  parameter int         FRAME_BYTES = 5,
  parameter int         HEADER_EN   = 1,
  parameter logic [7:0] HEADER_BASE = 8'hA0,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic                            Clk,
  input  logic                            Reset_n,
  input  logic [NUM_CH-1:0]               Req,
  input  logic [NUM_CH*FRAME_BYTES*8-1:0] Frame_Data,
  output logic [NUM_CH-1:0]               Ack,
  output logic [NUM_CH-1:0]               Done,
  output logic                            Timeout_Err,
  output logic                            Busy,
  output logic [7:0]                      Data,
  output logic                            send_go,
  input  logic                            tx_done
);

  localparam int FW      = FRAME_BYTES * 8;
  localparam int IDX_W   = $clog2(NUM_CH);
  localparam int SEQ_LEN = seq_bytes(FRAME_BYTES, HEADER_EN != 0);
  localparam int HDR_OFS = (HEADER_EN != 0) ? 1 : 0;
  localparam int CNT_W   = 4;
  localparam int WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEQ_LEN - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [IDX_W-1:0]  cur_ch_q, cur_ch_d;
  logic [FW-1:0]     shadow_q, shadow_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic              tout_q, tout_d;
  logic [7:0]        data_q, data_d;
  logic              go_q, go_d;

  logic              arb_valid;
  logic [NUM_CH-1:0] arb_grant;
  logic [IDX_W-1:0]  arb_idx;
  logic [FW-1:0]     win_frame;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req_i        (Req),
    .last_grant_i (last_grant_q),
    .valid_o      (arb_valid),
    .grant_o      (arb_grant),
    .idx_o        (arb_idx)
  );

  // Byte idx of the sequence: header (when enabled) then payload LSB first.
  function automatic logic [7:0] seq_byte(input logic [FW-1:0] frame,
                                          input logic [IDX_W-1:0] ch,
                                          input logic [CNT_W-1:0] idx);
    int k;
    if (HEADER_EN != 0 && idx == '0) return (HEADER_BASE & HDR_MASK) | 8'(ch);
    k = int'(idx) - HDR_OFS;
    return 8'(frame >> (8 * k));
  endfunction

  assign win_frame = FW'(Frame_Data >> (FW * int'(arb_idx)));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_ch_d     = cur_ch_q;
    shadow_d     = shadow_q;
    byte_cnt_d   = byte_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    ack_d        = '0;
    done_d       = '0;
    tout_d       = 1'b0;
    data_d       = data_q;
    go_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          ack_d      = arb_grant;
          shadow_d   = win_frame;
          cur_ch_d   = arb_idx;
          data_d     = seq_byte(win_frame, arb_idx, '0);
          go_d       = 1'b1;
          byte_cnt_d = '0;
          wd_cnt_d   = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // tx_done takes precedence over a watchdog expiry in the same cycle.
        if (tx_done) begin
          if (byte_cnt_q == CNT_LAST) begin
            done_d       = NUM_CH'(1) << cur_ch_q;
            last_grant_d = cur_ch_q;
            state_d      = IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            data_d     = seq_byte(shadow_q, cur_ch_q, byte_cnt_q + 1'b1);
            go_d       = 1'b1;
            wd_cnt_d   = '0;
          end
        end else if (TIMEOUT_CYC != 0 && wd_cnt_q == WD_LAST) begin
          tout_d       = 1'b1;
          last_grant_d = cur_ch_q;
          state_d      = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_CH - 1);
      cur_ch_q     <= '0;
      shadow_q     <= '0;
      byte_cnt_q   <= '0;
      wd_cnt_q     <= '0;
      ack_q        <= '0;
      done_q       <= '0;
      tout_q       <= 1'b0;
      data_q       <= '0;
      go_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_ch_q     <= cur_ch_d;
      shadow_q     <= shadow_d;
      byte_cnt_q   <= byte_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      tout_q       <= tout_d;
      data_q       <= data_d;
      go_q         <= go_d;
    end
  end

  assign Ack         = ack_q;
  assign Done        = done_q;
  assign Timeout_Err = tout_q;
  assign Busy        = (state_q == WAIT);
  assign Data        = data_q;
  assign send_go     = go_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic [3:0]   Req;
  logic [159:0] Frame_Data;
  logic         tx_done;
  logic [3:0]   Ack, Done;
  logic         Timeout_Err, Busy, send_go;
  logic [7:0]   Data;

  logic [1:0]   Req_b;
  logic [15:0]  Frame_Data_b;
  logic         tx_done_b;
  logic [1:0]   Ack_b, Done_b;
  logic         Timeout_Err_b, Busy_b, send_go_b;
  logic [7:0]   Data_b;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  uart_tx_scheduler #(
    .NUM_CH(4), .FRAME_BYTES(5), .HEADER_EN(1), .HEADER_BASE(8'hA0), .TIMEOUT_CYC(50)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Frame_Data(Frame_Data),
    .Ack(Ack), .Done(Done), .Timeout_Err(Timeout_Err), .Busy(Busy),
    .Data(Data), .send_go(send_go), .tx_done(tx_done)
  );

  uart_tx_scheduler #(
    .NUM_CH(2), .FRAME_BYTES(1), .HEADER_EN(0), .HEADER_BASE(8'hA0), .TIMEOUT_CYC(0)
  ) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req_b), .Frame_Data(Frame_Data_b),
    .Ack(Ack_b), .Done(Done_b), .Timeout_Err(Timeout_Err_b), .Busy(Busy_b),
    .Data(Data_b), .send_go(send_go_b), .tx_done(tx_done_b)
  );

  // Expected byte b of channel ch's sequence: header A0|ch, then payload LSB first.
  function automatic logic [7:0] exp_byte(input int ch, input int b);
    logic [39:0] f;
    f = 40'(Frame_Data >> (40 * ch));
    if (b == 0) return 8'hA0 | 8'(ch);
    return 8'(f >> (8 * (b - 1)));
  endfunction

  task automatic apply_reset();
    Reset_n = 1'b0; Req = '0; Req_b = '0; tx_done = 1'b0; tx_done_b = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    @(negedge Clk);
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Req = '0; Req_b = '0; tx_done = 1'b0; tx_done_b = 1'b0;
    @(negedge Clk);
    checks++; if (Ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b want 0000", Ack); end
    checks++; if (Done !== 4'b0) begin errors++; $display("FAIL reset_done: got %b want 0000", Done); end
    checks++; if (Timeout_Err !== 1'b0) begin errors++; $display("FAIL reset_tout: got %b want 0", Timeout_Err); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++; if (Data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", Data); end
    checks++; if (send_go !== 1'b0) begin errors++; $display("FAIL reset_go: got %b want 0", send_go); end
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    pulse_done();
    checks++;
    if (send_go !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL idle_txdone_ignored: go=%b busy=%b want 0 0", send_go, Busy);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp [6];
    exp = '{8'hA2, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    apply_reset();
    Req = 4'b0100;
    @(negedge Clk);
    Req = 4'b0000;
    checks++; if (Ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b want 0100", Ack); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", Busy); end
    for (int b = 0; b < 6; b++) begin
      checks++;
      if (send_go !== 1'b1 || Data !== exp[b]) begin
        errors++; $display("FAIL single_byte%0d: go=%b data=%h want 1 %h", b, send_go, Data, exp[b]);
      end
      repeat (2) begin
        @(negedge Clk);
        checks++;
        if (send_go !== 1'b0 || Ack !== 4'b0 || Done !== 4'b0) begin
          errors++; $display("FAIL single_quiet: go=%b ack=%b done=%b want 0", send_go, Ack, Done);
        end
      end
      pulse_done();
    end
    checks++; if (Done !== 4'b0100) begin errors++; $display("FAIL single_done: got %b want 0100", Done); end
    checks++; if (Busy !== 1'b0 || send_go !== 1'b0) begin errors++; $display("FAIL single_end: busy=%b go=%b want 0 0", Busy, send_go); end
    @(negedge Clk);
    checks++; if (Done !== 4'b0) begin errors++; $display("FAIL single_done_pulse: got %b want 0000", Done); end
  endtask

  task automatic test_back_to_back();
    int order [5];
    int ch;
    order = '{0, 1, 2, 3, 0};
    apply_reset();
    Req = 4'b1111;
    @(negedge Clk);
    for (int f = 0; f < 5; f++) begin
      ch = order[f];
      checks++;
      if (Ack !== 4'(1 << ch)) begin errors++; $display("FAIL rr_ack%0d: got %b want %b", f, Ack, 4'(1 << ch)); end
      for (int b = 0; b < 6; b++) begin
        checks++;
        if (send_go !== 1'b1 || Data !== exp_byte(ch, b)) begin
          errors++; $display("FAIL rr_byte f%0d b%0d: go=%b data=%h want 1 %h", f, b, send_go, Data, exp_byte(ch, b));
        end
        @(negedge Clk);
        pulse_done();
      end
      checks++;
      if (Done !== 4'(1 << ch) || send_go !== 1'b0) begin
        errors++; $display("FAIL rr_done%0d: done=%b go=%b want %b 0", f, Done, send_go, 4'(1 << ch));
      end
      if (f == 4) Req = 4'b0000;
      @(negedge Clk);
    end
    checks++;
    if (send_go !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL rr_idle: go=%b busy=%b want 0 0", send_go, Busy); end
  endtask

  task automatic test_fairness();
    apply_reset();
    Req = 4'b0001;
    @(negedge Clk);
    checks++; if (Ack !== 4'b0001) begin errors++; $display("FAIL fair_ack0: got %b want 0001", Ack); end
    Req = 4'b1001;
    for (int b = 0; b < 6; b++) begin
      @(negedge Clk);
      pulse_done();
    end
    checks++; if (Done !== 4'b0001) begin errors++; $display("FAIL fair_done0: got %b want 0001", Done); end
    @(negedge Clk);
    checks++; if (Ack !== 4'b1000) begin errors++; $display("FAIL fair_ch3_next: got %b want 1000", Ack); end
    Req = 4'b0001;
    for (int b = 0; b < 6; b++) begin
      checks++;
      if (Data !== exp_byte(3, b)) begin errors++; $display("FAIL fair_ch3_byte%0d: got %h want %h", b, Data, exp_byte(3, b)); end
      @(negedge Clk);
      pulse_done();
    end
    checks++; if (Done !== 4'b1000) begin errors++; $display("FAIL fair_done3: got %b want 1000", Done); end
    @(negedge Clk);
    checks++; if (Ack !== 4'b0001) begin errors++; $display("FAIL fair_regrant0: got %b want 0001", Ack); end
  endtask

  task automatic test_watchdog();
    apply_reset();
    Req = 4'b0011;
    @(negedge Clk);
    checks++; if (Ack !== 4'b0001) begin errors++; $display("FAIL wd_ack: got %b want 0001", Ack); end
    Req = 4'b0010;
    for (int c = 2; c <= 50; c++) begin
      @(negedge Clk);
      checks++;
      if (Timeout_Err !== 1'b0 || send_go !== 1'b0 || Busy !== 1'b1) begin
        errors++; $display("FAIL wd_early c%0d: tout=%b go=%b busy=%b want 0 0 1", c, Timeout_Err, send_go, Busy);
      end
    end
    @(negedge Clk);
    checks++; if (Timeout_Err !== 1'b1) begin errors++; $display("FAIL wd_pulse: got %b want 1", Timeout_Err); end
    checks++; if (Busy !== 1'b0 || Done !== 4'b0) begin errors++; $display("FAIL wd_abort: busy=%b done=%b want 0 0000", Busy, Done); end
    @(negedge Clk);
    checks++; if (Ack !== 4'b0010) begin errors++; $display("FAIL wd_next_ack: got %b want 0010", Ack); end
    checks++;
    if (send_go !== 1'b1 || Data !== 8'hA1 || Timeout_Err !== 1'b0) begin
      errors++; $display("FAIL wd_next_go: go=%b data=%h tout=%b want 1 a1 0", send_go, Data, Timeout_Err);
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    Req = 4'b0001;
    @(negedge Clk);
    Req = 4'b0000;
    repeat (3) begin
      @(negedge Clk);
      pulse_done();
    end
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({Ack, Done, Timeout_Err, Busy, Data, send_go} !== 19'b0) begin
      errors++; $display("FAIL midrst_outputs: ack=%b done=%b tout=%b busy=%b data=%h go=%b want all 0",
                         Ack, Done, Timeout_Err, Busy, Data, send_go);
    end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    checks++; if (Busy !== 1'b0 || send_go !== 1'b0) begin errors++; $display("FAIL midrst_idle: busy=%b go=%b want 0 0", Busy, send_go); end
    Req = 4'b0001;
    @(negedge Clk);
    Req = 4'b0000;
    checks++;
    if (Ack !== 4'b0001 || send_go !== 1'b1 || Data !== 8'hA0) begin
      errors++; $display("FAIL midrst_fresh: ack=%b go=%b data=%h want 0001 1 a0", Ack, send_go, Data);
    end
    @(negedge Clk);
    pulse_done();
    checks++; if (send_go !== 1'b1 || Data !== 8'hC4) begin errors++; $display("FAIL midrst_byte1: go=%b data=%h want 1 c4", send_go, Data); end
  endtask

  task automatic test_header_off();
    int gos;
    apply_reset();
    Req_b = 2'b01;
    @(negedge Clk);
    Req_b = 2'b00;
    checks++; if (Ack_b !== 2'b01) begin errors++; $display("FAIL hdroff_ack: got %b want 01", Ack_b); end
    checks++; if (send_go_b !== 1'b1 || Data_b !== 8'h5A) begin errors++; $display("FAIL hdroff_byte: go=%b data=%h want 1 5a", send_go_b, Data_b); end
    gos = 0;
    repeat (3) begin @(negedge Clk); if (send_go_b) gos++; end
    checks++; if (gos !== 0) begin errors++; $display("FAIL hdroff_extra_go: got %0d want 0", gos); end
    tx_done_b = 1'b1;
    @(negedge Clk);
    tx_done_b = 1'b0;
    checks++;
    if (Done_b !== 2'b01 || send_go_b !== 1'b0 || Busy_b !== 1'b0) begin
      errors++; $display("FAIL hdroff_done: done=%b go=%b busy=%b want 01 0 0", Done_b, send_go_b, Busy_b);
    end
    gos = 0;
    repeat (3) begin @(negedge Clk); if (send_go_b) gos++; end
    checks++; if (gos !== 0 || Timeout_Err_b !== 1'b0) begin errors++; $display("FAIL hdroff_after: gos=%0d tout=%b want 0 0", gos, Timeout_Err_b); end
  endtask

  initial begin
    Reset_n = 1'b0; Req = '0; Req_b = '0; tx_done = 1'b0; tx_done_b = 1'b0;
    Frame_Data   = {40'hE0E1E2E3E4, 40'h1122334455, 40'hD0D1D2D3D4, 40'hC0C1C2C3C4};
    Frame_Data_b = {8'h77, 8'h5A};
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_watchdog();
    test_reset_mid_frame();
    test_header_off();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
